// File: rtl/updown_counter_pkg.sv
// Shared counter definitions: direction encoding and default geometry.
// Imported by the counter interface and the counter itself.
package updown_counter_pkg;

    typedef enum logic {
        DirDown = 1'b0,
        DirUp   = 1'b1
    } dir_e;

    localparam int unsigned DefaultWidth   = 6;
    localparam int unsigned DefaultModulus = 64;

endpackage

// File: rtl/updown_counter_if.sv
// Control and status bundle of the up/down counter.
// The master drives the controls; the counter itself uses the slave view.
interface updown_counter_if
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, din,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, din,
        output count, tc, wrap
    );

endinterface

// File: rtl/updown_counter.sv
// Modulo-MODULUS up/down counter with saturating parallel load, a combinational
// terminal count and a registered wrap pulse. Synchronous active-low clear.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned MODULUS = DefaultModulus
) (
    input logic             clk,
    input logic             clear,
    updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             tc;

    always_comb begin
        tc = bus.en & ((bus.up == DirUp) ? (count_q == MaxVal) : (count_q == '0));
    end

    // Clear is applied in the register; this only covers load and count.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = (bus.din > MaxVal) ? MaxVal : bus.din;
        end else if (bus.en) begin
            wrap_d = tc;
            if (bus.up == DirUp) begin
                count_d = (count_q == MaxVal) ? '0 : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? MaxVal : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a WIDTH=6/MODULUS=64 instance and a
// WIDTH=4/MODULUS=10 instance, driven on the falling edge and checked after it.
module tb_updown_counter;

    logic clk = 1'b0;
    logic clear_a, clear_b;

    int n_checks = 0;
    int n_errors = 0;

    updown_counter_if #(.WIDTH(6)) bus_a ();
    updown_counter_if #(.WIDTH(4)) bus_b ();

    updown_counter #(.WIDTH(6), .MODULUS(64)) u_dut_a (
        .clk   (clk),
        .clear (clear_a),
        .bus   (bus_a)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut_b (
        .clk   (clk),
        .clear (clear_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         clear;
        bit         load;
        bit         en;
        bit         up;
        logic [3:0] din;
        bit         tc;
        int         count;
        bit         wrap;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // tc is checked before the edge, count and wrap just after it.
    task automatic step_a(input bit c, input bit l, input bit e, input bit u,
                          input logic [5:0] d, input bit exp_tc, input int exp_count,
                          input bit exp_wrap, input string name);
        @(negedge clk);
        clear_a    = c;
        bus_a.load = l;
        bus_a.en   = e;
        bus_a.up   = u;
        bus_a.din  = d;
        #1;
        check({name, " tc"}, 32'(bus_a.tc), 32'(exp_tc));
        @(posedge clk);
        #1;
        check({name, " count"}, 32'(bus_a.count), exp_count);
        check({name, " wrap"}, 32'(bus_a.wrap), 32'(exp_wrap));
    endtask

    task automatic step_b(input vec_t v, input string name);
        @(negedge clk);
        clear_b    = v.clear;
        bus_b.load = v.load;
        bus_b.en   = v.en;
        bus_b.up   = v.up;
        bus_b.din  = v.din;
        #1;
        check({name, " tc"}, 32'(bus_b.tc), 32'(v.tc));
        @(posedge clk);
        #1;
        check({name, " count"}, 32'(bus_b.count), v.count);
        check({name, " wrap"}, 32'(bus_b.wrap), 32'(v.wrap));
    endtask

    initial begin
        clear_a = 1'b1; bus_a.load = 1'b0; bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.din = '0;
        clear_b = 1'b1; bus_b.load = 1'b0; bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.din = '0;

        // MODULUS=10 vectors: {clear, load, en, up, din, tc, count, wrap}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 0, 1'b0};  // reset
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 0, 1'b0};  // clear beats load/en
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 9, 1'b0};  // load saturates
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 5, 1'b0};  // load beats en, no wrap
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 6, 1'b0};  // up/down toggling
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 5, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 6, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 5, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 9, 1'b0};  // max din saturates
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 0, 1'b1};  // up wrap 9->0
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 0, 1'b0};  // wrap lasts one cycle
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 9, 1'b1};  // down wrap 0->9
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 0, 1'b0};  // clear at terminal count
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 0, 1'b0};  // tc needs en
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1, 1'b0};  // resume from 0
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 9, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 9, 1'b0};  // din == MODULUS
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            step_b(vecs[i], $sformatf("vec%0d", i));
        end

        // MODULUS=10 count-down from reset: 0, 9, 8, ..., 0, 9
        step_b('{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0}, "down reset");
        for (int i = 0; i < 12; i++) begin
            int pre;
            vec_t v;
            pre = (10 - (i % 10)) % 10;
            v = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, (pre == 0), (pre + 9) % 10, (pre == 0)};
            step_b(v, $sformatf("down%0d", i));
        end
        bus_b.en = 1'b0;

        // MODULUS=64 full up-count from reset over 65 edges
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 0, 1'b0, "up reset");
        for (int i = 0; i < 65; i++) begin
            step_a(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, ((i % 64) == 63), (i + 1) % 64,
                   ((i % 64) == 63), $sformatf("up%0d", i));
        end

        // Clear at count 63 with en/up: no wrap afterwards
        step_a(1'b1, 1'b1, 1'b0, 1'b1, 6'd63, 1'b0, 63, 1'b0, "ld63");
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 0, 1'b0, "clr at 63");
        step_a(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 0, 1'b0, "after clr");

        // Hold at 17 with en low
        step_a(1'b1, 1'b1, 1'b0, 1'b1, 6'd17, 1'b0, 17, 1'b0, "ld17");
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, 1'b0, 1'b0, i[0], 6'd40, 1'b0, 17, 1'b0, $sformatf("hold%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 6, meaning count register width in bits.
REQ-002 The module SHALL have parameter MODULUS, default 64 (2**WIDTH), meaning count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port clear  input  1  reset; synchronous and active-low.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  parallel load strobe.
REQ-008 Port din  input  WIDTH  parallel load value.
REQ-009 Port count  output  WIDTH  registered current count.
REQ-010 Port tc  output  1  combinational terminal count for the current direction.
REQ-011 Port wrap  output  1  registered one-cycle pulse marking a wrap-around.

Function
REQ-012 Priority per edge SHALL be clear > load > en; with none active, count SHALL hold.
REQ-013 On load, count SHALL take din next edge; if din >= MODULUS, count SHALL take MODULUS-1 (saturate).
REQ-014 On en with up=1, count SHALL become count+1, or 0 when count == MODULUS-1.
REQ-015 On en with up=0, count SHALL become count-1, or MODULUS-1 when count == 0.
REQ-016 Arithmetic SHALL be modulo MODULUS, never 2**WIDTH, when MODULUS < 2**WIDTH.
REQ-017 tc SHALL equal en & (up ? count == MODULUS-1 : count == 0), with no added latency.
REQ-018 wrap SHALL be 1 for exactly the cycle after an edge at which tc was 1 and no load or clear occurred; otherwise 0.
REQ-019 Direction change mid-count SHALL take effect on the same edge up is sampled; no pipeline.
REQ-020 load and en both high SHALL load only; wrap SHALL be 0 the next cycle.
REQ-021 count SHALL never hold a value >= MODULUS after any edge.

Reset
REQ-022 clear=0 at a rising edge SHALL set count=0 and wrap=0, overriding load and en.
REQ-023 clear SHALL have no effect between edges; the outputs change only at clk rising edges.
REQ-024 Reset mid-count SHALL discard the pending increment/decrement; counting SHALL resume from 0 on the first enabled edge after clear returns to 1.

Structure
REQ-025 Direction encodings (UP=1, DOWN=0) and the default WIDTH/MODULUS SHALL live in the shared counter include file used by counter blocks.
REQ-026 The block SHALL be a single module with no sub-module; the next-state logic and the tc compare are inline.
REQ-027 Implementation SHALL be fully synchronous (no rippled clocks, no flip-flop output used as a clock).

Verification
REQ-028 WIDTH=6, MODULUS=64, up=1, en=1 from reset for 65 edges -> count 0..63, 0; tc high at 63; wrap high the cycle count shows 0.
REQ-029 WIDTH=4, MODULUS=10, up=0, en=1 from reset -> count 0, 9, 8, ..., 0, 9; tc high at 0; wrap pulses after each 0->9 step.
REQ-030 MODULUS=10, load=1, din=12 -> count=9; then load=1, din=5, en=1 same edge -> count=5, wrap=0.
REQ-031 MODULUS=64, count=63, up=1, en=1, clear=0 same edge -> count=0, wrap=0 next cycle.
REQ-032 count=5, en=1, up toggled every edge 1,0,1,0 -> count 6, 5, 6, 5; tc stays 0.
REQ-033 en=0 for 10 edges at count=17 -> count holds 17; tc=0; wrap=0.
